// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator: absorbs one unsigned operand per beat in
// carry-save form and resolves the frame total with one carry-propagate add.
module csa_accumulator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GUARD = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH+GUARD-1:0] out_sum,
    output logic [GUARD:0]         out_count,
    output logic                   out_ovf
);

    localparam int unsigned ACC_WIDTH = WIDTH + GUARD;
    localparam int unsigned CNT_WIDTH = GUARD + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] OVF_LIM = CNT_WIDTH'(1) << GUARD;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e                 state_q,     state_d;
    logic [ACC_WIDTH-1:0]   s_q,         s_d;
    logic [ACC_WIDTH-1:0]   c_q,         c_d;
    logic [CNT_WIDTH-1:0]   cnt_q,       cnt_d;
    logic                   in_ready_q,  in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]   out_sum_q,   out_sum_d;
    logic [CNT_WIDTH-1:0]   out_count_q, out_count_d;
    logic                   out_ovf_q,   out_ovf_d;
    logic [ACC_WIDTH-1:0]   x_c;
    logic                   accept_c;

    // Next-state, carry-save update and result capture
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        x_c         = ACC_WIDTH'(in_data);
        accept_c    = in_valid & in_ready_q;

        case (state_q)
            IDLE: state_d = ACCUM;
            ACCUM: begin
                if (accept_c) begin
                    s_d   = s_q ^ c_q ^ x_c;
                    c_d   = ((s_q & c_q) | (s_q & x_c) | (c_q & x_c)) << 1;
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                    if (in_last) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                out_sum_d   = s_q + c_q;
                out_count_d = cnt_q;
                out_ovf_d   = (cnt_q > OVF_LIM);
                s_d         = '0;
                c_d         = '0;
                cnt_d       = '0;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered copies of the next state
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: directed frames with literal results plus a
// modular-sum reference model checked on every result presentation.
module tb_csa_accumulator;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned GUARD     = 4;
    localparam int unsigned ACC_WIDTH = WIDTH + GUARD;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [GUARD:0]       out_count;
    logic                 out_ovf;

    csa_accumulator #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer sum and beat count of the current frame
    longint acc_m = 0;
    int     cnt_m = 0;
    longint exp_sum_q[$];
    int     exp_cnt_q[$];
    int     exp_ovf_q[$];

    task automatic model_clear();
        acc_m = 0;
        cnt_m = 0;
        exp_sum_q.delete();
        exp_cnt_q.delete();
        exp_ovf_q.delete();
    endtask

    task automatic model_beat(input int d, input logic last);
        acc_m += d;
        cnt_m++;
        if (last) begin
            exp_sum_q.push_back(acc_m % (longint'(1) << ACC_WIDTH));
            exp_cnt_q.push_back(cnt_m > 31 ? 31 : cnt_m);
            exp_ovf_q.push_back(cnt_m > 16 ? 1 : 0);
            acc_m = 0;
            cnt_m = 0;
        end
    endtask

    // out_ready driver: directed value, or random stalls
    logic rand_mode   = 1'b0;
    logic out_rdy_dir = 1'b1;
    always @(negedge clk) begin
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
        else           out_ready = out_rdy_dir;
    end

    // Compare process: result on first valid cycle, stability while held
    logic                 prev_valid = 1'b0;
    logic [ACC_WIDTH-1:0] held_sum;
    logic [GUARD:0]       held_cnt;
    logic                 held_ovf;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) check("in_ready_low_while_valid", longint'(in_ready), 0);
            if (out_valid && !prev_valid) begin
                if (exp_sum_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    check("out_sum", longint'(out_sum), exp_sum_q.pop_front());
                    check("out_count", longint'(out_count), longint'(exp_cnt_q.pop_front()));
                    check("out_ovf", longint'(out_ovf), longint'(exp_ovf_q.pop_front()));
                end
                held_sum = out_sum;
                held_cnt = out_count;
                held_ovf = out_ovf;
            end else if (out_valid) begin
                check("sum_stable", longint'(out_sum), longint'(held_sum));
                check("count_stable", longint'(out_count), longint'(held_cnt));
                check("ovf_stable", longint'(out_ovf), longint'(held_ovf));
            end
            prev_valid = out_valid;
        end
    end

    // Present one beat and hold it until accepted
    task automatic send(input int d, input logic last);
        int budget;
        budget = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = WIDTH'(d);
        in_last  = last;
        while (!in_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            check("beat_accept_timeout", 1, 0);
        end else begin
            model_beat(d, last);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 300);
        if (!out_valid) check("out_valid_timeout", 1, 0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 1, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_sum", longint'(out_sum), 0);
        check("rst_out_count", longint'(out_count), 0);
        check("rst_out_ovf", longint'(out_ovf), 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_before_first_edge", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        check("in_ready_first_edge", longint'(in_ready), 1);
    endtask

    initial begin
        #300_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int len;
        #1;
        check("init_in_ready", longint'(in_ready), 0);
        check("init_out_valid", longint'(out_valid), 0);
        #20;
        do_reset();

        // Frame 3,5,7: latency and literal result
        send(3, 1'b0);
        send(5, 1'b0);
        send(7, 1'b1);
        wait_valid(n);
        check("latency_negedges", longint'(n), 2);
        check("lit_sum_15", longint'(out_sum), 15);
        check("lit_count_3", longint'(out_count), 3);
        check("lit_ovf_0", longint'(out_ovf), 0);

        // 16 beats of all-ones: no wrap
        for (int i = 0; i < 16; i++) send(255, i == 15);
        wait_valid(n);
        check("lit_sum_4080", longint'(out_sum), 4080);
        check("lit_count_16", longint'(out_count), 16);
        check("lit_ovf_16", longint'(out_ovf), 0);

        // 17 beats of all-ones: wrap and ovf
        for (int i = 0; i < 17; i++) send(255, i == 16);
        wait_valid(n);
        check("lit_sum_239", longint'(out_sum), 239);
        check("lit_count_17", longint'(out_count), 17);
        check("lit_ovf_17", longint'(out_ovf), 1);

        // Single beat under backpressure
        wait_ready();
        @(posedge clk);
        #1;
        out_rdy_dir = 1'b0;
        send(200, 1'b1);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", longint'(out_valid), 1);
            check("bp_out_sum", longint'(out_sum), 200);
            check("bp_in_ready", longint'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_rdy_dir = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", longint'(in_ready), 1);
        check("bp_release_out_valid", longint'(out_valid), 0);
        check("bp_hold_sum", longint'(out_sum), 200);
        check("bp_hold_count", longint'(out_count), 1);

        // Reset mid-frame discards partial sum
        send(10, 1'b0);
        send(20, 1'b0);
        do_reset();
        send(9, 1'b1);
        wait_valid(n);
        check("lit_sum_9", longint'(out_sum), 9);
        check("lit_count_1", longint'(out_count), 1);

        // Random frames with input gaps and output stalls
        rand_mode = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 12);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 2) == 0) begin
                    repeat ($urandom_range(1, 3)) begin
                        @(negedge clk);
                        in_valid = 1'b0;
                        in_data  = WIDTH'($urandom);
                        in_last  = 1'($urandom);
                    end
                end
                send(int'($urandom_range(0, 255)), b == len - 1);
            end
        end
        n = 0;
        while ((exp_sum_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("all_results_drained", longint'(exp_sum_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
